// File: rtl/pe_v03.sv
// Registered, config-loaded processing element: joins neighbour operands, runs one
// ALU op per fire for ITER fires (or forever when ITER is 0), registers every result.
module pe_v03 #(
    parameter int DATA_W = 8,
    parameter int ITER_W = 8,
    localparam int CFG_W = DATA_W + ITER_W + 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid_i,
    input  logic [CFG_W-1:0]  cfg_word_i,
    output logic              cfg_ready_o,
    input  logic              cfg_clear_i,
    input  logic [DATA_W-1:0] in_e_i,
    input  logic [DATA_W-1:0] in_s_i,
    input  logic [DATA_W-1:0] in_w_i,
    input  logic [DATA_W-1:0] in_n_i,
    input  logic [3:0]        in_vld_i,
    output logic [DATA_W-1:0] out_e_o,
    output logic [DATA_W-1:0] out_s_o,
    output logic [DATA_W-1:0] out_w_o,
    output logic [DATA_W-1:0] out_n_o,
    output logic [3:0]        out_vld_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_vld_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q, state_d;
    logic [CFG_W-1:0]    cfg_q, cfg_d;
    logic [ITER_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   r0_q, r1_q, mem_q;
    logic                mem_vld_q, done_q;

    logic [2:0]          op, src1, src2, dst;
    logic [ITER_W-1:0]   iter;
    logic [DATA_W-1:0]   imm;

    assign op   = cfg_q[2:0];
    assign src2 = cfg_q[5:3];
    assign src1 = cfg_q[8:6];
    assign dst  = cfg_q[11:9];
    assign iter = cfg_q[12 +: ITER_W];
    assign imm  = cfg_q[12+ITER_W +: DATA_W];

    // Returns {operand_valid, operand}; register, immediate and zero sources are always valid.
    function automatic logic [DATA_W:0] pick(input logic [2:0] code);
        logic [DATA_W:0] r;
        r = {1'b1, {DATA_W{1'b0}}};
        case (code)
            3'd0:    r = {in_vld_i[0], in_e_i};
            3'd1:    r = {in_vld_i[1], in_s_i};
            3'd2:    r = {in_vld_i[2], in_w_i};
            3'd3:    r = {in_vld_i[3], in_n_i};
            3'd4:    r = {1'b1, r0_q};
            3'd5:    r = {1'b1, r1_q};
            3'd6:    r = {1'b1, imm};
            default: r = {1'b1, {DATA_W{1'b0}}};
        endcase
        return r;
    endfunction

    logic [DATA_W:0]   pick_a, pick_b;
    logic [DATA_W-1:0] opa, opb, res;
    logic              fire, last_fire;

    assign pick_a = pick(src1);
    assign pick_b = pick(src2);
    assign opa    = pick_a[DATA_W-1:0];
    assign opb    = pick_b[DATA_W-1:0];

    // A clear in the same cycle wins over a fire, so that result never appears.
    assign fire      = (state_q == RUN) && !cfg_clear_i && pick_a[DATA_W] && pick_b[DATA_W];
    assign last_fire = fire && (iter != '0) && (cnt_q == iter - ITER_W'(1));

    always_comb begin
        res = '0;
        case (op)
            3'd0:    res = opa + opb;
            3'd1:    res = opa - opb;
            3'd2:    res = opa * opb;
            3'd3:    res = (opb == '0) ? '1 : opa / opb;
            3'd4:    res = opa & opb;
            3'd5:    res = opa | opb;
            3'd6:    res = opa ^ opb;
            default: res = opa;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        cnt_d       = cnt_q;
        cfg_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_ready_o = 1'b1;
                if (cfg_valid_i) begin
                    cfg_d   = cfg_word_i;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cfg_clear_i) begin
                    state_d = IDLE;
                end else if (fire) begin
                    cnt_d = cnt_q + ITER_W'(1);
                    if (last_fire) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cfg_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Directional outputs {N,W,S,E}: data holds, valid pulses for one cycle.
    logic [3:0][DATA_W-1:0] out_data;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dir
            logic [DATA_W-1:0] data_q;
            logic              vld_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q <= '0;
                    vld_q  <= 1'b0;
                end else begin
                    vld_q <= fire && (dst == 3'(gi));
                    if (fire && (dst == 3'(gi))) data_q <= res;
                end
            end
            assign out_data[gi]  = data_q;
            assign out_vld_o[gi] = vld_q;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q     <= '0;
            mem_vld_q <= 1'b0;
            r0_q      <= '0;
            r1_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            mem_vld_q <= fire && (dst == 3'd4);
            done_q    <= last_fire;
            if (fire && (dst == 3'd4)) mem_q <= res;
            if (fire && (dst == 3'd5)) r0_q  <= res;
            if (fire && (dst == 3'd6)) r1_q  <= res;
        end
    end

    assign out_e_o    = out_data[0];
    assign out_s_o    = out_data[1];
    assign out_w_o    = out_data[2];
    assign out_n_o    = out_data[3];
    assign mem_data_o = mem_q;
    assign mem_vld_o  = mem_vld_q;
    assign done_o     = done_q;
    assign busy_o     = (state_q == RUN);

endmodule

// File: tb/tb_pe_v03.sv
// Scoreboard bench for pe_v03: a behavioural model predicts every visible result,
// a negedge monitor pops and compares whenever the PE presents a valid or done.
module tb_pe_v03;

    localparam int DW = 8;
    localparam int IW = 8;
    localparam int CW = DW + IW + 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid, cfg_ready, cfg_clear;
    logic [CW-1:0] cfg_word;
    logic [DW-1:0] in_e, in_s, in_w, in_n;
    logic [3:0]    in_vld, out_vld;
    logic [DW-1:0] out_e, out_s, out_w, out_n, mem_data;
    logic          mem_vld, busy, done;

    pe_v03 #(.DATA_W(DW), .ITER_W(IW)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid_i(cfg_valid), .cfg_word_i(cfg_word), .cfg_ready_o(cfg_ready),
        .cfg_clear_i(cfg_clear),
        .in_e_i(in_e), .in_s_i(in_s), .in_w_i(in_w), .in_n_i(in_n), .in_vld_i(in_vld),
        .out_e_o(out_e), .out_s_o(out_s), .out_w_o(out_w), .out_n_o(out_n),
        .out_vld_o(out_vld), .mem_data_o(mem_data), .mem_vld_o(mem_vld),
        .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int       due;
        int       dst;
        logic [3:0] ovld;
        logic     mvld;
        logic     dn;
        int       val;
    } exp_t;
    exp_t sb[$];

    // Behavioural model of the kernel being run.
    bit m_run;
    int m_op, m_s1, m_s2, m_dst, m_iter, m_imm, m_cnt, m_r0, m_r1;

    function automatic logic [CW-1:0] mkcfg(int imm, int iter, int dst, int s1, int s2, int op);
        return {imm[7:0], iter[7:0], dst[2:0], s1[2:0], s2[2:0], op[2:0]};
    endfunction

    function automatic int alu(int op, int a, int b);
        case (op)
            0: return (a + b) % 256;
            1: return (a - b + 256) % 256;
            2: return (a * b) % 256;
            3: return (b == 0) ? 255 : a / b;
            4: return a & b;
            5: return a | b;
            6: return a ^ b;
            default: return a;
        endcase
    endfunction

    function automatic int src_val(int code, int e, int s, int w, int n);
        case (code)
            0: return e;
            1: return s;
            2: return w;
            3: return n;
            4: return m_r0;
            5: return m_r1;
            6: return m_imm;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_run = 0; m_op = 0; m_s1 = 0; m_s2 = 0; m_dst = 0;
        m_iter = 0; m_imm = 0; m_cnt = 0; m_r0 = 0; m_r1 = 0;
        sb.delete();
    endtask

    task automatic model_step(bit cv, logic [CW-1:0] cw, bit clr, int e, int s, int w, int n,
                              logic [3:0] vld);
        bit   ok1, ok2, fin;
        int   a, b, r;
        exp_t x;
        if (!m_run) begin
            if (cv) begin
                m_op = int'(cw[2:0]);   m_s2 = int'(cw[5:3]); m_s1 = int'(cw[8:6]);
                m_dst = int'(cw[11:9]); m_iter = int'(cw[19:12]); m_imm = int'(cw[27:20]);
                m_cnt = 0; m_run = 1;
            end
        end else if (clr) begin
            m_run = 0;
        end else begin
            ok1 = (m_s1 > 3) || vld[m_s1];
            ok2 = (m_s2 > 3) || vld[m_s2];
            if (ok1 && ok2) begin
                a = src_val(m_s1, e, s, w, n);
                b = src_val(m_s2, e, s, w, n);
                r = alu(m_op, a, b);
                fin = (m_iter != 0) && (m_cnt == m_iter - 1);
                if (m_dst == 5) m_r0 = r;
                if (m_dst == 6) m_r1 = r;
                if (m_dst <= 4 || fin) begin
                    x.due = cyc + 1; x.dst = m_dst; x.val = r; x.dn = fin;
                    x.ovld = (m_dst < 4) ? 4'(1 << m_dst) : 4'b0000;
                    x.mvld = (m_dst == 4);
                    sb.push_back(x);
                end
                m_cnt = (m_cnt + 1) % 256;
                if (fin) m_run = 0;
            end
        end
    endtask

    task automatic chk(string name, int got, int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // Called at posedge+1; applies inputs for one cycle and returns at the next posedge+1.
    task automatic drive(bit cv, logic [CW-1:0] cw, bit clr, int e, int s, int w, int n,
                         logic [3:0] vld);
        cfg_valid = cv; cfg_word = cw; cfg_clear = clr;
        in_e = e[7:0]; in_s = s[7:0]; in_w = w[7:0]; in_n = n[7:0]; in_vld = vld;
        chk("busy", int'(busy), int'(m_run));
        chk("cfg_ready", int'(cfg_ready), int'(!m_run));
        model_step(cv, cw, clr, e, s, w, n, vld);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int k);
        for (int i = 0; i < k; i++) drive(0, '0, 0, 0, 0, 0, 0, 4'b0000);
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_outs"}, int'(out_e | out_s | out_w | out_n | mem_data), 0);
        chk({tag, "_vlds"}, int'({out_vld, mem_vld, done}), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_cfg_ready"}, int'(cfg_ready), 1);
    endtask

    // Monitor: pops one expectation whenever the PE presents a result or done.
    always @(negedge clk) begin
        if (!rst) begin
            if ((|out_vld) || mem_vld || done) begin
                if (sb.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_output: cyc=%0d vld=%b mem_vld=%b done=%b required none",
                             cyc, out_vld, mem_vld, done);
                end else begin
                    exp_t x;
                    int   got;
                    x = sb.pop_front();
                    case (x.dst)
                        0: got = int'(out_e);
                        1: got = int'(out_s);
                        2: got = int'(out_w);
                        3: got = int'(out_n);
                        4: got = int'(mem_data);
                        default: got = x.val;
                    endcase
                    n_chk++;
                    if (cyc != x.due || out_vld != x.ovld || mem_vld != x.mvld || done != x.dn
                        || got != x.val) begin
                        n_fail++;
                        $display("FAIL result: cyc=%0d vld=%b mem_vld=%b done=%b data=%0d required cyc=%0d vld=%b mem_vld=%b done=%b data=%0d",
                                 cyc, out_vld, mem_vld, done, got, x.due, x.ovld, x.mvld, x.dn, x.val);
                    end else begin
                        $display("result cyc=%0d dst=%0d data=%0d done=%b", cyc, x.dst, got, done);
                    end
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                exp_t x;
                x = sb.pop_front();
                n_chk++; n_fail++;
                $display("FAIL missing_output: cyc=%0d nothing presented required dst=%0d data=%0d done=%b",
                         cyc, x.dst, x.val, x.dn);
            end
        end
    end

    initial begin
        logic [CW-1:0] cw;
        int            e;
        int            s;
        rst = 1'b1;
        cfg_valid = 0; cfg_word = '0; cfg_clear = 0;
        in_e = 0; in_s = 0; in_w = 0; in_n = 0; in_vld = 0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        // ADD E+S -> out_e, single iteration
        drive(1, mkcfg(0, 1, 0, 0, 1, 0), 0, 0, 0, 0, 0, 4'b0000);
        drive(0, '0, 0, 5, 7, 0, 0, 4'b0011);
        chk("add_out_e", int'(out_e), 12);
        chk("add_done", int'(done), 1);
        chk("add_out_vld", int'(out_vld), 1);
        idle(1);

        // Operand join W+N -> mem: no fire until both valids present
        drive(1, mkcfg(0, 1, 4, 2, 3, 0), 0, 0, 0, 0, 0, 4'b0000);
        for (int i = 0; i < 3; i++) drive(0, '0, 0, 0, 0, 10, 20, 4'b0100);
        drive(0, '0, 0, 0, 0, 10, 20, 4'b1100);
        chk("join_mem", int'(mem_data), 30);

        // Accumulate imm=3 into R0 four times, then read R0 out to mem
        drive(1, mkcfg(3, 4, 5, 4, 6, 0), 0, 0, 0, 0, 0, 4'b0000);
        idle(4);
        drive(1, mkcfg(0, 1, 4, 4, 7, 7), 0, 0, 0, 0, 0, 4'b0000);
        idle(1);
        chk("acc_r0", int'(mem_data), 12);

        // DIV by zero, SUB wrap, MUL overflow, loaded back-to-back
        drive(1, mkcfg(0, 1, 4, 1, 0, 3), 0, 0, 0, 0, 0, 4'b0000);
        drive(0, '0, 0, 0, 9, 0, 0, 4'b0011);
        chk("div0", int'(mem_data), 255);
        drive(1, mkcfg(0, 1, 4, 0, 1, 1), 0, 0, 0, 0, 0, 4'b0000);
        drive(0, '0, 0, 3, 5, 0, 0, 4'b0011);
        chk("sub_wrap", int'(mem_data), 254);
        drive(1, mkcfg(0, 1, 4, 0, 1, 2), 0, 0, 0, 0, 0, 4'b0000);
        drive(0, '0, 0, 16, 16, 0, 0, 4'b0011);
        chk("mul_wrap", int'(mem_data), 0);

        // Continuous kernel: ten fires, then clear coinciding with a fire
        drive(1, mkcfg(0, 0, 2, 0, 1, 0), 0, 0, 0, 0, 0, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            e = int'($urandom_range(0, 255));
            s = int'($urandom_range(0, 255));
            drive(0, '0, 0, e, s, 0, 0, 4'b1111);
        end
        drive(0, '0, 1, 1, 2, 3, 4, 4'b1111);
        chk("clear_drop_vld", int'({out_vld, mem_vld, done}), 0);
        idle(1);

        // Random kernels, with cfg_valid and occasional clear during RUN
        for (int k = 0; k < 40; k++) begin
            cw = mkcfg(int'($urandom_range(0, 255)), int'($urandom_range(0, 5)),
                       int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            drive(1, cw, 0, 0, 0, 0, 0, 4'b0000);
            for (int t = 0; t < 30 && m_run; t++) begin
                drive(($urandom_range(0, 3) == 0), mkcfg(1, 1, 4, 6, 6, 0),
                      ($urandom_range(0, 29) == 0),
                      int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      4'($urandom_range(0, 15)));
            end
            if (m_run) drive(0, '0, 1, 0, 0, 0, 0, 4'b0000);
        end

        // Asynchronous reset mid-run, off the clock edge
        drive(1, mkcfg(90, 0, 3, 6, 7, 5), 0, 0, 0, 0, 0, 4'b0000);
        idle(3);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk_all_zero("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        drive(1, mkcfg(0, 1, 1, 0, 1, 6), 0, 0, 0, 0, 0, 4'b0000);
        drive(0, '0, 0, 8'hF0, 8'h3C, 0, 0, 4'b0011);
        chk("post_rst_xor", int'(out_s), 8'hCC);
        idle(3);

        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
